// File: rtl/usb_pkg.sv
// Shared PID constants and enums for the USB host transaction sequencer.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [1:0] {
        PT_NONE      = 2'b00,
        PT_TOKEN     = 2'b01,
        PT_DATA      = 2'b10,
        PT_HANDSHAKE = 2'b11
    } pkt_type_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOK,
        S_TOK_W,
        S_DTX,
        S_DTX_W,
        S_RXH,
        S_RXD,
        S_HTX,
        S_HTX_W,
        S_FIN
    } state_e;

    typedef enum logic [1:0] {
        XS_OK      = 2'b00,
        XS_NAK     = 2'b01,
        XS_TIMEOUT = 2'b10,
        XS_CRC     = 2'b11
    } status_e;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_rx_timer.sv
// Receive-phase response timer: held clear outside a receive phase, counts while enabled.
module usb_rx_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt;

    // Saturates at the last count so it can never wrap back to zero
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/usb_xfer_ctrl.sv
// Host-side USB transaction sequencer: token, data/handshake, retries and completion status.
// Define USB_DATA_TOGGLE_EN to track DATA0/DATA1 sequencing with a toggle bit.
import usb_pkg::*;

module usb_xfer_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    output logic       tx_start,
    output logic [1:0] tx_type,
    output logic [3:0] tx_pid,
    input  logic       tx_done,
    output logic       rx_en,
    input  logic       rx_done,
    input  logic [3:0] rx_pid,
    input  logic       rx_crc_ok,
    output logic       xfer_done,
    output logic [1:0] xfer_status
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_e        state;
    logic          rw_q;
    logic [RW-1:0] retry_cnt;
    logic          in_rx;
    logic          expired;
    logic          rx_fail;
    status_e       fail_cause;
    logic [3:0]    data_pid;

    assign in_rx = (state == S_RXH) || (state == S_RXD);

    usb_rx_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx_timer (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (!in_rx),
        .en      (in_rx),
        .expired (expired)
    );

`ifdef USB_DATA_TOGGLE_EN
    logic toggle;
    logic toggle_flip;

    assign data_pid    = toggle ? PID_DATA1 : PID_DATA0;
    assign toggle_flip = rx_done &&
                         (((state == S_RXH) && (rx_pid == PID_ACK)) ||
                          ((state == S_RXD) && rx_crc_ok && (rx_pid == data_pid)));

    // Only a matching DATAx advances the IN sequence; a mismatch is still ACKed
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            toggle <= 1'b0;
        end else if (toggle_flip) begin
            toggle <= ~toggle;
        end
    end
`else
    assign data_pid = PID_DATA0;
`endif

    // rx_done in the same cycle as the timeout takes priority
    always_comb begin
        rx_fail    = 1'b0;
        fail_cause = XS_CRC;
        if (state == S_RXH) begin
            if (rx_done) begin
                if (rx_pid == PID_NAK) begin
                    rx_fail    = 1'b1;
                    fail_cause = XS_NAK;
                end else if (rx_pid != PID_ACK) begin
                    rx_fail    = 1'b1;
                    fail_cause = XS_CRC;
                end
            end else if (expired) begin
                rx_fail    = 1'b1;
                fail_cause = XS_TIMEOUT;
            end
        end else if (state == S_RXD) begin
            if (rx_done) begin
                if (rx_pid == PID_NAK) begin
                    rx_fail    = 1'b1;
                    fail_cause = XS_NAK;
                end else if (!(is_data_pid(rx_pid) && rx_crc_ok)) begin
                    rx_fail    = 1'b1;
                    fail_cause = XS_CRC;
                end
            end else if (expired) begin
                rx_fail    = 1'b1;
                fail_cause = XS_TIMEOUT;
            end
        end
    end

    // Outputs are set on state entry so rx_en/req_ready/xfer_done line up with their states
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            tx_start    <= 1'b0;
            tx_type     <= PT_NONE;
            tx_pid      <= 4'h0;
            rx_en       <= 1'b0;
            xfer_done   <= 1'b0;
            xfer_status <= XS_OK;
            rw_q        <= 1'b0;
            retry_cnt   <= '0;
        end else begin
            tx_start  <= 1'b0;
            xfer_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        rw_q      <= req_rw;
                        retry_cnt <= '0;
                        req_ready <= 1'b0;
                        state     <= S_TOK;
                    end
                end
                S_TOK: begin
                    tx_start <= 1'b1;
                    tx_type  <= PT_TOKEN;
                    tx_pid   <= rw_q ? PID_OUT : PID_IN;
                    state    <= S_TOK_W;
                end
                S_TOK_W: begin
                    if (tx_done) begin
                        tx_type <= PT_NONE;
                        tx_pid  <= 4'h0;
                        rx_en   <= !rw_q;
                        state   <= rw_q ? S_DTX : S_RXD;
                    end
                end
                S_DTX: begin
                    tx_start <= 1'b1;
                    tx_type  <= PT_DATA;
                    tx_pid   <= data_pid;
                    state    <= S_DTX_W;
                end
                S_DTX_W: begin
                    if (tx_done) begin
                        tx_type <= PT_NONE;
                        tx_pid  <= 4'h0;
                        rx_en   <= 1'b1;
                        state   <= S_RXH;
                    end
                end
                S_RXH, S_RXD: begin
                    if (rx_fail) begin
                        rx_en <= 1'b0;
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= S_TOK;
                        end else begin
                            xfer_done   <= 1'b1;
                            xfer_status <= fail_cause;
                            state       <= S_FIN;
                        end
                    end else if (rx_done) begin
                        rx_en <= 1'b0;
                        if (state == S_RXH) begin
                            xfer_done   <= 1'b1;
                            xfer_status <= XS_OK;
                            state       <= S_FIN;
                        end else begin
                            state <= S_HTX;
                        end
                    end
                end
                S_HTX: begin
                    tx_start <= 1'b1;
                    tx_type  <= PT_HANDSHAKE;
                    tx_pid   <= PID_ACK;
                    state    <= S_HTX_W;
                end
                S_HTX_W: begin
                    if (tx_done) begin
                        tx_type     <= PT_NONE;
                        tx_pid      <= 4'h0;
                        xfer_done   <= 1'b1;
                        xfer_status <= XS_OK;
                        state       <= S_FIN;
                    end
                end
                S_FIN: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_xfer_ctrl.sv
// Self-checking bench for usb_xfer_ctrl: reactive line model plus a transfer-level reference model.
module tb_usb_xfer_ctrl;

    localparam int TO   = 8;
    localparam int MAXR = 3;

    localparam logic [3:0] P_OUT = 4'b0001;
    localparam logic [3:0] P_IN  = 4'b1001;
    localparam logic [3:0] P_D0  = 4'b0011;
    localparam logic [3:0] P_D1  = 4'b1011;
    localparam logic [3:0] P_ACK = 4'b0010;
    localparam logic [3:0] P_NAK = 4'b1010;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rw = 1'b0;
    logic       tx_done = 1'b0;
    logic       rx_done = 1'b0;
    logic [3:0] rx_pid = 4'h0;
    logic       rx_crc_ok = 1'b0;
    logic       req_ready;
    logic       tx_start;
    logic [1:0] tx_type;
    logic [3:0] tx_pid;
    logic       rx_en;
    logic       xfer_done;
    logic [1:0] xfer_status;

    int errors = 0;
    int checks = 0;

    // Device response script: one entry per receive phase
    bit         resp_reply[4];
    logic [3:0] resp_pid[4];
    bit         resp_crc[4];
    int         resp_delay[4];

    logic [1:0] exp_type[$];
    logic [3:0] exp_pid[$];
    logic [1:0] exp_status;
    int         exp_phases;
    bit         m_tog = 1'b0;

    usb_xfer_ctrl #(
        .TIMEOUT_CYC (TO),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .tx_start    (tx_start),
        .tx_type     (tx_type),
        .tx_pid      (tx_pid),
        .tx_done     (tx_done),
        .rx_en       (rx_en),
        .rx_done     (rx_done),
        .rx_pid      (rx_pid),
        .rx_crc_ok   (rx_crc_ok),
        .xfer_done   (xfer_done),
        .xfer_status (xfer_status)
    );

    always #5 clk = ~clk;

    task automatic clear_resp();
        for (int i = 0; i < 4; i++) begin
            resp_reply[i] = 1'b0;
            resp_pid[i]   = 4'h0;
            resp_crc[i]   = 1'b0;
            resp_delay[i] = 1;
        end
    endtask

    task automatic set_resp(input int i, input logic [3:0] pid, input bit crc, input int delay);
        resp_reply[i] = 1'b1;
        resp_pid[i]   = pid;
        resp_crc[i]   = crc;
        resp_delay[i] = delay;
    endtask

    // Transfer-level model: packet list, attempt count and final status from the retry rules
    task automatic build_expect(input bit rw);
        int attempt;
        int idx;
        bit ok;
        logic [1:0] cause;
        logic [3:0] want_data;
        exp_type.delete();
        exp_pid.delete();
        attempt = 0;
        idx = 0;
        forever begin
            exp_type.push_back(2'b01);
            exp_pid.push_back(rw ? P_OUT : P_IN);
            want_data = m_tog ? P_D1 : P_D0;
            if (rw) begin
                exp_type.push_back(2'b10);
                exp_pid.push_back(want_data);
            end
            ok = 1'b0;
            cause = 2'b11;
            if (!resp_reply[idx]) begin
                cause = 2'b10;
            end else if (rw) begin
                if (resp_pid[idx] == P_ACK) begin
                    ok = 1'b1;
`ifdef USB_DATA_TOGGLE_EN
                    m_tog = !m_tog;
`endif
                end else if (resp_pid[idx] == P_NAK) begin
                    cause = 2'b01;
                end
            end else begin
                if ((resp_pid[idx] == P_D0 || resp_pid[idx] == P_D1) && resp_crc[idx]) begin
                    ok = 1'b1;
                    exp_type.push_back(2'b11);
                    exp_pid.push_back(P_ACK);
`ifdef USB_DATA_TOGGLE_EN
                    if (resp_pid[idx] == want_data) m_tog = !m_tog;
`endif
                end else if (resp_pid[idx] == P_NAK) begin
                    cause = 2'b01;
                end
            end
            idx++;
            if (ok) begin
                exp_status = 2'b00;
                break;
            end
            if (attempt < MAXR) begin
                attempt++;
            end else begin
                exp_status = cause;
                break;
            end
        end
        exp_phases = idx;
    endtask

    task automatic run_xfer(input bit rw, input int txd, input bit stray, input string name);
        bit tx_busy = 1'b0;
        bit just_done = 1'b0;
        bit prev_rx = 1'b0;
        bit done = 1'b0;
        int tx_wait = 0;
        int rx_age = 0;
        int ridx = 0;
        bit cur_reply = 1'b0;
        int cur_delay = 0;
        logic [1:0] cur_type = 2'b00;
        logic [3:0] cur_pid = 4'h0;
        build_expect(rw);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ready_idle: got %b expected 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_rw = rw;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (tx_start === 1'b1) begin
                checks++;
                if (exp_type.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s tx_extra: got %b/%b expected no packet", name, tx_type, tx_pid);
                end else begin
                    if (tx_type !== exp_type[0] || tx_pid !== exp_pid[0]) begin
                        errors++;
                        $display("[TB] FAIL %s tx_seq: got %b/%b expected %b/%b",
                                 name, tx_type, tx_pid, exp_type[0], exp_pid[0]);
                    end
                    void'(exp_type.pop_front());
                    void'(exp_pid.pop_front());
                end
                tx_busy = 1'b1;
                cur_type = tx_type;
                cur_pid = tx_pid;
                tx_wait = (txd > 0) ? txd : int'($urandom_range(1, 20));
            end else if (tx_busy) begin
                checks++;
                if (tx_type !== cur_type || tx_pid !== cur_pid) begin
                    errors++;
                    $display("[TB] FAIL %s tx_hold: got %b/%b expected %b/%b",
                             name, tx_type, tx_pid, cur_type, cur_pid);
                end
            end
            if (just_done) begin
                checks++;
                if (tx_type !== 2'b00 || tx_pid !== 4'h0) begin
                    errors++;
                    $display("[TB] FAIL %s tx_clear: got %b/%b expected 00/0000", name, tx_type, tx_pid);
                end
                just_done = 1'b0;
            end
            if (tx_busy) begin
                checks++;
                if (rx_en !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s rx_en_during_tx: got %b expected 0", name, rx_en);
                end
            end
            if (rx_en === 1'b1 && !prev_rx) begin
                if (ridx < 4) begin
                    cur_reply = resp_reply[ridx];
                    cur_delay = resp_delay[ridx];
                end else begin
                    cur_reply = 1'b0;
                end
                ridx++;
                rx_age = 0;
            end
            if (rx_en !== 1'b1 && prev_rx) begin
                checks++;
                if (rx_age != (cur_reply ? cur_delay : TO)) begin
                    errors++;
                    $display("[TB] FAIL %s rx_window: got %0d cycles expected %0d",
                             name, rx_age, cur_reply ? cur_delay : TO);
                end
            end
            prev_rx = (rx_en === 1'b1);
            if (xfer_done === 1'b1) begin
                checks++;
                if (xfer_status !== exp_status) begin
                    errors++;
                    $display("[TB] FAIL %s status: got %b expected %b", name, xfer_status, exp_status);
                end
                checks++;
                if (exp_type.size() != 0 || ridx != exp_phases) begin
                    errors++;
                    $display("[TB] FAIL %s attempts: got %0d rx phases, %0d packets missing, expected %0d phases",
                             name, ridx, exp_type.size(), exp_phases);
                end
                done = 1'b1;
            end else begin
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s ready_busy: got %b expected 0", name, req_ready);
                end
            end
            // Drive inputs for the next edge
            tx_done = 1'b0;
            rx_done = 1'b0;
            rx_pid = 4'($urandom);
            rx_crc_ok = 1'($urandom);
            req_valid = (stray && !done) ? 1'($urandom) : 1'b0;
            req_rw = 1'($urandom);
            if (done) begin
                // nothing more to drive
            end else if (tx_busy) begin
                tx_wait--;
                if (tx_wait <= 0) begin
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                    just_done = 1'b1;
                end
            end else if (stray && $urandom_range(0, 7) == 0) begin
                tx_done = 1'b1;
            end
            if (!done && rx_en === 1'b1) begin
                rx_age++;
                if (cur_reply && rx_age == cur_delay) begin
                    rx_done = 1'b1;
                    rx_pid = resp_pid[ridx - 1];
                    rx_crc_ok = resp_crc[ridx - 1];
                end
            end else if (!done && stray && $urandom_range(0, 7) == 0) begin
                rx_done = 1'b1;
            end
        end
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s xfer_done_timeout: got no completion expected status %b", name, exp_status);
        end else begin
            @(posedge clk);
            #1;
            checks++;
            if (xfer_done !== 1'b0 || req_ready !== 1'b1 || xfer_status !== exp_status) begin
                errors++;
                $display("[TB] FAIL %s after_done: got done=%b ready=%b status=%b expected 0/1/%b",
                         name, xfer_done, req_ready, xfer_status, exp_status);
            end
        end
        tx_done = 1'b0;
        rx_done = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({req_ready, tx_start, tx_type, tx_pid, rx_en, xfer_done, xfer_status} !== 12'b1_0_00_0000_0_0_00) begin
            errors++;
            $display("[TB] FAIL %s reset_outputs: got %b expected 100000000000", name,
                     {req_ready, tx_start, tx_type, tx_pid, rx_en, xfer_done, xfer_status});
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_b = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_out_ack();
        clear_resp();
        set_resp(0, P_ACK, 1'b1, 6);
        run_xfer(1'b1, 20, 1'b0, "out_ack");
    endtask

    task automatic test_in_good();
        clear_resp();
        set_resp(0, m_tog ? P_D1 : P_D0, 1'b1, 5);
        run_xfer(1'b0, 0, 1'b0, "in_good");
    endtask

    task automatic test_out_nak();
        clear_resp();
        for (int i = 0; i < 4; i++) set_resp(i, P_NAK, 1'b1, int'($urandom_range(1, TO)));
        run_xfer(1'b1, 0, 1'b0, "out_nak");
    endtask

    task automatic test_in_timeout();
        clear_resp();
        run_xfer(1'b0, 0, 1'b0, "in_timeout");
    endtask

    task automatic test_in_crc_recover();
        clear_resp();
        set_resp(0, m_tog ? P_D1 : P_D0, 1'b0, 3);
        set_resp(1, m_tog ? P_D1 : P_D0, 1'b1, TO);
        run_xfer(1'b0, 0, 1'b0, "in_crc_recover");
    endtask

    task automatic test_back_to_back();
        clear_resp();
        set_resp(0, P_ACK, 1'b1, 2);
        run_xfer(1'b1, 0, 1'b0, "b2b_first");
        run_xfer(1'b1, 0, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 25; n++) begin
            clear_resp();
            for (int i = 0; i < 4; i++) begin
                k = int'($urandom_range(0, 9));
                case (k)
                    0, 1:    ;
                    2, 3:    set_resp(i, P_NAK, 1'($urandom), int'($urandom_range(1, TO)));
                    4, 5:    set_resp(i, P_ACK, 1'($urandom), int'($urandom_range(1, TO)));
                    6, 7:    set_resp(i, ($urandom_range(0, 1) == 1) ? P_D1 : P_D0, 1'b1, int'($urandom_range(1, TO)));
                    8:       set_resp(i, 4'($urandom), 1'($urandom), int'($urandom_range(1, TO)));
                    default: set_resp(i, P_D0, $urandom_range(0, 3) != 0, int'($urandom_range(1, TO)));
                endcase
            end
            run_xfer(1'($urandom), 0, 1'b1, $sformatf("random%0d", n));
        end
    endtask

    task automatic test_reset_mid();
        bit got_rx = 1'b0;
        bit saw_done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rw = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        tx_done = 1'b1;
        for (int i = 0; i < 50 && !got_rx; i++) begin
            @(negedge clk);
            if (rx_en === 1'b1) got_rx = 1'b1;
        end
        tx_done = 1'b0;
        checks++;
        if (!got_rx) begin
            errors++;
            $display("[TB] FAIL reset_mid reach_rx: got rx_en=%b expected 1", rx_en);
        end
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        repeat (3) begin
            @(negedge clk);
            if (xfer_done === 1'b1) saw_done = 1'b1;
        end
        rst_b = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (xfer_done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("[TB] FAIL reset_mid no_done: got xfer_done=1 expected 0");
        end
        check_reset_outputs("reset_mid_after");
        m_tog = 1'b0;
        clear_resp();
        set_resp(0, P_ACK, 1'b1, 4);
        run_xfer(1'b1, 0, 1'b0, "post_reset_out");
    endtask

    initial begin
        test_reset();
        test_out_ack();
        test_in_good();
        test_out_nak();
        test_in_timeout();
        test_in_crc_recover();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no end of run expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
